// File: rtl/snake_dir_input_pkg.sv
// Shared types for the snake direction input block: heading encoding and debounce FSM states.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_t;

    // Up/down and left/right differ only in bit 0, so the reverse heading is a single bit flip.
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/snake_dir_input_if.sv
// Bundle of button inputs and debounced/direction outputs of the snake direction input block.
// Latency: n/a (wiring only).
// Backpressure: none; dir_valid is a strobe the consumer must take on the cycle it is high.
// Ports: key_in (raw buttons), key_stable/key_pulse (per-key debounced level/edge), dir/dir_valid.
interface snake_dir_input_if;
    logic [3:0]       key_in;
    logic [3:0]       key_stable;
    logic [3:0]       key_pulse;
    snake_pkg::dir_t  dir;
    logic             dir_valid;

    // master: the direction block itself
    modport master (
        input  key_in,
        output key_stable,
        output key_pulse,
        output dir,
        output dir_valid
    );

    // slave: button source and downstream direction latch
    modport slave (
        output key_in,
        input  key_stable,
        input  key_pulse,
        input  dir,
        input  dir_valid
    );
endinterface

// File: rtl/snake_dir_input_key_debounce.sv
// One push-button: 2-flop synchronizer, STABLE/PENDING debounce FSM, rising-edge pulse flop.
// Latency: key_stable follows a clean level change DEB_CYCLES+1 edges after first sample; pulse one edge later.
// Backpressure: none; the pulse is a single-cycle strobe.
// Ports: clk, rst_n (async active-low), key_raw (async button), key_stable, key_pulse.
module key_debounce
    import snake_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_stable,
    output logic key_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             pulse_q;

    // State register, including the synchronizer and the edge-detect flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q       <= 1'b0;
            sync_q       <= 1'b0;
            state_q      <= ST_STABLE;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            meta_q       <= key_raw;
            sync_q       <= meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            // Pulse reflects a 0->1 of key_stable made on the previous edge.
            pulse_q      <= stable_q & ~stable_dly_q;
        end
    end

    // Next-state: the counter tracks how many consecutive samples disagreed with stable_q.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        unique case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync_q != stable_q) begin
                    state_d = ST_PENDING;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PENDING: begin
                if (sync_q == stable_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // This sample is the DEB_CYCLES-th disagreement in a row.
                    stable_d = sync_q;
                    state_d  = ST_STABLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        key_stable = stable_q;
        key_pulse  = pulse_q;
    end

endmodule

// File: rtl/snake_dir_input.sv
// Debounces four direction buttons and keeps the snake heading, rejecting reversals and repeats.
// Latency: press to dir/dir_valid is DEB_CYCLES+3 edges.
// Backpressure: none; dir_valid is a one-cycle strobe for the downstream direction latch.
// Ports: clk, rst_n (async active-low), bus (snake_dir_input_if.master).
module snake_dir_input
    import snake_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    snake_dir_input_if.master        bus
);

    logic [3:0] stable_w;
    logic [3:0] pulse_w;
    dir_t       cand;
    logic       accept;
    dir_t       dir_q;
    logic       dir_valid_q;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_raw    (bus.key_in[g]),
            .key_stable (stable_w[g]),
            .key_pulse  (pulse_w[g])
        );
    end

    // Only the highest-priority pulse is considered; if it is rejected, lower
    // simultaneous pulses are ignored rather than tried in turn.
    always_comb begin
        cand = DIR_RIGHT;
        if (pulse_w[0])      cand = DIR_UP;
        else if (pulse_w[1]) cand = DIR_DOWN;
        else if (pulse_w[2]) cand = DIR_LEFT;
        accept = (|pulse_w) && (cand != dir_q) && (cand != opposite(dir_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= DIR_RIGHT;
            dir_valid_q <= 1'b0;
        end else begin
            if (accept) dir_q <= cand;
            dir_valid_q <= accept;
        end
    end

    assign bus.key_stable = stable_w;
    assign bus.key_pulse  = pulse_w;
    assign bus.dir        = dir_q;
    assign bus.dir_valid  = dir_valid_q;

endmodule

// File: tb/tb_snake_dir_input.sv
module tb_snake_dir_input;
    import snake_pkg::*;

    localparam int DEB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    snake_dir_input_if bus ();

    snake_dir_input #(.DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt [4];
    int   tick_idx;
    int   stable_rise;
    int   first_pulse;
    int   first_valid;
    int   valid_cnt;
    int   viol = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [3:0] keys;
        logic [3:0] exp_pulse;
        logic [1:0] exp_dir;
        int         exp_valid;
    } vec_t;

    vec_t vecs [12];

    // dir_valid must never be high on two consecutive cycles.
    always @(negedge clk) begin
        if (!rst_n) prev_valid = 1'b0;
        else begin
            if (bus.dir_valid && prev_valid) viol++;
            prev_valid = bus.dir_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 4; k++) pulse_cnt[k] = 0;
        tick_idx    = 0;
        stable_rise = -1;
        first_pulse = -1;
        first_valid = -1;
        valid_cnt   = 0;
    endtask

    task automatic run_keys(input logic [3:0] keys, input int n);
        bus.key_in = keys;
        for (int i = 0; i < n; i++) begin
            tick();
            tick_idx++;
            for (int k = 0; k < 4; k++) begin
                if (bus.key_pulse[k]) begin
                    pulse_cnt[k]++;
                    if (first_pulse < 0) first_pulse = tick_idx;
                end
            end
            if (stable_rise < 0 && bus.key_stable != 4'b0) stable_rise = tick_idx;
            if (bus.dir_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = tick_idx;
            end
        end
    endtask

    function automatic int total_pulses();
        return pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
    endfunction

    function automatic logic [3:0] pulse_mask();
        logic [3:0] m;
        for (int k = 0; k < 4; k++) m[k] = (pulse_cnt[k] != 0);
        return m;
    endfunction

    function automatic logic [10:0] outs();
        return {bus.key_stable, bus.key_pulse, bus.dir, bus.dir_valid};
    endfunction

    localparam logic [10:0] RST_OUTS = {4'b0000, 4'b0000, 2'b11, 1'b0};

    initial begin
        // starting from dir=10 after the bounce test
        vecs[0]  = '{4'b0001, 4'b0001, 2'b00, 1};  // up: accepted
        vecs[1]  = '{4'b1000, 4'b1000, 2'b11, 1};  // right: accepted
        vecs[2]  = '{4'b0100, 4'b0100, 2'b11, 0};  // left vs right: opposite
        vecs[3]  = '{4'b1000, 4'b1000, 2'b11, 0};  // right vs right: same
        vecs[4]  = '{4'b0101, 4'b0101, 2'b00, 1};  // up+left: up wins
        vecs[5]  = '{4'b0010, 4'b0010, 2'b00, 0};  // down vs up: opposite
        vecs[6]  = '{4'b0100, 4'b0100, 2'b10, 1};  // left: accepted
        vecs[7]  = '{4'b0010, 4'b0010, 2'b01, 1};  // down: accepted
        vecs[8]  = '{4'b0110, 4'b0110, 2'b01, 0};  // down+left: down same, no fall-through
        vecs[9]  = '{4'b1001, 4'b1001, 2'b01, 0};  // up+right: up opposite, no fall-through
        vecs[10] = '{4'b1000, 4'b1000, 2'b11, 1};  // right: accepted
        vecs[11] = '{4'b0001, 4'b0001, 2'b00, 1};  // up: accepted

        // 1. reset
        bus.key_in = 4'b0000;
        #2 rst_n = 1'b0;
        #1 check("reset_async", 32'(outs()), 32'(RST_OUTS));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_hold%0d", i), 32'(outs()), 32'(RST_OUTS));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("reset_idle%0d", i), 32'(outs()), 32'(RST_OUTS));
        end

        // 2. clean press of up
        clear_stats();
        run_keys(4'b0001, 20);
        check("clean_stable_rise", 32'(stable_rise), 32'd10);
        check("clean_pulse_at",    32'(first_pulse), 32'd11);
        check("clean_pulse_cnt",   32'(total_pulses()), 32'd1);
        check("clean_valid_at",    32'(first_valid), 32'd12);
        check("clean_valid_cnt",   32'(valid_cnt), 32'd1);
        check("clean_dir",         32'(bus.dir), 32'(DIR_UP));
        clear_stats();
        run_keys(4'b0000, 20);
        check("release_quiet", 32'({bus.key_stable, 4'(total_pulses()), 4'(valid_cnt)}), 32'd0);
        check("release_dir",   32'(bus.dir), 32'(DIR_UP));

        // 3. bouncing left, then steady from tick 25
        clear_stats();
        for (int r = 0; r < 4; r++) begin
            run_keys(4'b0100, 3);
            run_keys(4'b0000, 3);
        end
        run_keys(4'b0100, 12);
        check("bounce_stable_rise", 32'(stable_rise), 32'd34);
        check("bounce_pulse_at",    32'(first_pulse), 32'd35);
        check("bounce_pulse_cnt",   32'(pulse_cnt[2]), 32'd1);
        check("bounce_pulse_total", 32'(total_pulses()), 32'd1);
        check("bounce_valid_at",    32'(first_valid), 32'd36);
        check("bounce_dir",         32'(bus.dir), 32'(DIR_LEFT));
        clear_stats();
        run_keys(4'b0000, 20);
        check("bounce_release", 32'({bus.key_stable, 4'(total_pulses())}), 32'd0);

        // 4/5. accept/reject table
        for (int v = 0; v < 12; v++) begin
            clear_stats();
            run_keys(vecs[v].keys, 14);
            check($sformatf("vec%0d_pulse_mask", v), 32'(pulse_mask()), 32'(vecs[v].exp_pulse));
            check($sformatf("vec%0d_pulse_total", v), 32'(total_pulses()), 32'($countones(vecs[v].exp_pulse)));
            check($sformatf("vec%0d_dir", v), 32'(bus.dir), 32'(vecs[v].exp_dir));
            check($sformatf("vec%0d_valid_cnt", v), 32'(valid_cnt), 32'(vecs[v].exp_valid));
            clear_stats();
            run_keys(4'b0000, 14);
            check($sformatf("vec%0d_release", v),
                  32'({bus.key_stable, 4'(total_pulses()), 4'(valid_cnt)}), 32'd0);
        end

        // 6. reset in the middle of a debounce count (dir is 00 here)
        clear_stats();
        run_keys(4'b0001, 6);
        rst_n = 1'b0;
        #1 check("midreset_async", 32'(outs()), 32'(RST_OUTS));
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("midreset_hold%0d", i), 32'(outs()), 32'(RST_OUTS));
        end
        rst_n = 1'b1;
        clear_stats();
        run_keys(4'b0001, 14);
        check("midreset_stable_rise", 32'(stable_rise), 32'd10);
        check("midreset_valid_at",    32'(first_valid), 32'd12);
        check("midreset_dir",         32'(bus.dir), 32'(DIR_UP));
        clear_stats();
        run_keys(4'b0000, 14);

        check("no_back_to_back_valid", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
